nibble_serial_addsub_ctrl: RTL



---
 rtl/nibble_serial_addsub_pkg.sv | 15 +
 rtl/nibble_addsub.sv | 25 ++
 rtl/nibble_serial_addsub_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package nibble_serial_addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NIB_W = 4;

    function automatic int idx_width(input int width);
        return $clog2(width / NIB_W);
    endfunction

endpackage

// File: rtl/nibble_addsub.sv
// 4-bit add/sub slice: a ripple of four full-adder cells.
module nibble_addsub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       inv,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] b_x;
    logic [4:0] c;

    // inv only flips b; cin carries the chained borrow/carry between nibbles
    assign b_x  = b ^ {4{inv}};
    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b_x[i] ^ c[i];
        assign c[i+1] = (a[i] & b_x[i]) | (c[i] & (a[i] ^ b_x[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract over one shared 4-bit slice, LSB nibble first.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDSUB_OVF_EN.
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(WIDTH);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sub_q, sub_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               accept;
    logic               last;
    logic [NIB_W-1:0]   slice_s;
    logic               slice_c;

    assign accept = (state_q == IDLE) && start;
    assign last   = (idx_q == IDX_W'(NIB - 1));

    nibble_addsub u_slice (
        .a    (a_q[{idx_q, 2'b00} +: NIB_W]),
        .b    (b_q[{idx_q, 2'b00} +: NIB_W]),
        .inv  (sub_q),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        result_d = result_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            // carry seeded with op_sub completes the two's-complement negate of b
            a_d      = a;
            b_d      = b;
            sub_d    = op_sub;
            carry_d  = op_sub;
            idx_d    = '0;
            result_d = '0;
        end else if (state_q == RUN) begin
            result_d[{idx_q, 2'b00} +: NIB_W] = slice_s;
            carry_d = slice_c;
            if (last) begin
                idx_d  = '0;
                cout_d = slice_c;
                done_d = 1'b1;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
                ovf_d  = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                         (slice_s[NIB_W-1] != a_q[WIDTH-1]);
`endif
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        ready  = (state_q == IDLE);
        busy   = (state_q == RUN);
        done   = done_q;
        result = result_q;
        cout   = cout_q;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
        ovf    = ovf_q;
`endif
    end

endmodule
